// File: rtl/param_parking_controller_pkg.sv
// Shared definitions for the parking entry-gate controller: FSM state
// encodings and the cause recorded when the gate is blocked.
package param_parking_controller_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PIN = 3'd1,
    BAD_PIN  = 3'd2,
    OPEN     = 3'd3,
    CLOSING  = 3'd4,
    BLOCKED  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_PIN      = 2'd1,
    CAUSE_TAILGATE = 2'd2
  } cause_t;

endpackage

// File: rtl/param_parking_controller_occupancy_counter.sv
// Saturating up/down vehicle counter; a simultaneous inc and dec cancel out.
module occupancy_counter #(
  parameter int CAPACITY = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inc,
  input  logic                               dec,
  output logic [$clog2(CAPACITY+1)-1:0]      count,
  output logic                               full
);

  localparam int W = $clog2(CAPACITY + 1);
  localparam logic [W-1:0] CAP = W'(CAPACITY);

  // NOTE: rst is synchronous, so it is tested inside the clocked branch only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && count != CAP) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign full = (count == CAP);

endmodule

// File: rtl/param_parking_controller.sv
// Entry-gate controller: PIN check with attempt limit, gate handshake,
// tailgate detection and occupancy tracking. Optional PARKING_TIMEOUT_EN
// adds a PIN-entry timeout in WAIT_PIN.
module param_parking_controller
  import param_parking_controller_pkg::*;
#(
  parameter int                CODE_W         = 16,
  parameter logic [CODE_W-1:0] CORRECT_CODE   = 16'h5990,
  parameter int                MAX_ATTEMPTS   = 3,
  parameter int                CAPACITY       = 8,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 vehicle_arrival,
  input  logic                                 vehicle_left,
  input  logic [CODE_W-1:0]                    code,
  input  logic                                 code_ack,
  input  logic                                 gate_ack,
  input  logic                                 vehicle_exit,
  input  logic                                 unblock,
  output logic                                 open_gate,
  output logic                                 close_gate,
  output logic                                 wrong_pin,
  output logic                                 blocked_gate,
  output logic                                 lot_full,
  output logic [$clog2(CAPACITY+1)-1:0]        occupancy,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    attempts
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [ATT_W-1:0] MAX_ATT = ATT_W'(MAX_ATTEMPTS);

  if (MAX_ATTEMPTS < 1 || CAPACITY < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("param_parking_controller: illegal parameter value");
  end

  state_t            state, state_next;
  cause_t            cause, cause_next;
  logic [ATT_W-1:0]  attempts_next;
  logic              inc;
  logic              timeout;

`ifdef PARKING_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  logic [TMR_W-1:0] timer;

  // Every path into WAIT_PIN passes through another state, which zeroes the timer.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_PIN) timer <= '0;
    else                          timer <= timer + 1'b1;
  end

  assign timeout = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cause    <= CAUSE_NONE;
      attempts <= '0;
    end else begin
      state    <= state_next;
      cause    <= cause_next;
      attempts <= attempts_next;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next    = state;
    cause_next    = cause;
    attempts_next = attempts;
    inc           = 1'b0;
    case (state)
      IDLE: begin
        if (vehicle_arrival && !lot_full) state_next = WAIT_PIN;
      end
      WAIT_PIN: begin
        if (vehicle_left) begin
          state_next    = IDLE;
          attempts_next = '0;
        end else if (code_ack) begin
          if (code == CORRECT_CODE) begin
            state_next    = OPEN;
            attempts_next = '0;
          end else begin
            state_next = BAD_PIN;
          end
        end else if (timeout) begin
          state_next    = IDLE;
          attempts_next = '0;
        end
      end
      BAD_PIN: begin
        if (!code_ack) begin
          attempts_next = attempts + 1'b1;
          if (attempts_next == MAX_ATT) begin
            state_next = BLOCKED;
            cause_next = CAUSE_PIN;
          end else begin
            state_next = WAIT_PIN;
          end
        end
      end
      OPEN: begin
        attempts_next = '0;
        if (vehicle_left) begin
          inc = 1'b1;
          if (vehicle_arrival) begin
            state_next = BLOCKED;
            cause_next = CAUSE_TAILGATE;
          end else begin
            state_next = CLOSING;
          end
        end
      end
      CLOSING: begin
        if (gate_ack) state_next = IDLE;
      end
      BLOCKED: begin
        if (unblock) begin
          state_next    = IDLE;
          cause_next    = CAUSE_NONE;
          attempts_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        cause_next    = CAUSE_NONE;
        attempts_next = '0;
      end
    endcase
  end

  occupancy_counter #(
    .CAPACITY(CAPACITY)
  ) u_occupancy (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (vehicle_exit),
    .count (occupancy),
    .full  (lot_full)
  );

  assign open_gate    = (state == OPEN);
  assign close_gate   = (state == CLOSING);
  assign wrong_pin    = (state == BLOCKED) && (cause == CAUSE_PIN);
  assign blocked_gate = (state == BLOCKED) && (cause == CAUSE_TAILGATE);

endmodule

// File: tb/tb_param_parking_controller.sv
// Directed bench for param_parking_controller (CAPACITY=2, TIMEOUT_CYCLES=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_param_parking_controller;

  localparam int CODE_W         = 16;
  localparam int MAX_ATTEMPTS   = 3;
  localparam int CAPACITY       = 2;
  localparam int TIMEOUT_CYCLES = 8;
  localparam logic [15:0] GOOD  = 16'h5990;
  localparam logic [15:0] BAD   = 16'h1234;

  logic              clk = 1'b0;
  logic              rst;
  logic              vehicle_arrival, vehicle_left, code_ack, gate_ack;
  logic              vehicle_exit, unblock;
  logic [CODE_W-1:0] code;
  logic              open_gate, close_gate, wrong_pin, blocked_gate, lot_full;
  logic [1:0]        occupancy;
  logic [1:0]        attempts;

  int checks = 0;
  int errors = 0;

  param_parking_controller #(
    .CODE_W         (CODE_W),
    .CORRECT_CODE   (GOOD),
    .MAX_ATTEMPTS   (MAX_ATTEMPTS),
    .CAPACITY       (CAPACITY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .vehicle_arrival (vehicle_arrival),
    .vehicle_left    (vehicle_left),
    .code            (code),
    .code_ack        (code_ack),
    .gate_ack        (gate_ack),
    .vehicle_exit    (vehicle_exit),
    .unblock         (unblock),
    .open_gate       (open_gate),
    .close_gate      (close_gate),
    .wrong_pin       (wrong_pin),
    .blocked_gate    (blocked_gate),
    .lot_full        (lot_full),
    .occupancy       (occupancy),
    .attempts        (attempts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vehicle_arrival = 1'b0; vehicle_left = 1'b0; code_ack = 1'b0;
    gate_ack = 1'b0; vehicle_exit = 1'b0; unblock = 1'b0; code = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Full admission from IDLE; ends back in IDLE with inputs idle.
  task automatic admit();
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0; code = GOOD; code_ack = 1'b1; tick();
    code_ack = 1'b0; vehicle_left = 1'b1; tick();
    vehicle_left = 1'b0; gate_ack = 1'b1; tick();
    gate_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_open", open_gate, 0);
    check("rst_close", close_gate, 0);
    check("rst_wrong", wrong_pin, 0);
    check("rst_blocked", blocked_gate, 0);
    check("rst_full", lot_full, 0);
    check("rst_occ", occupancy, 0);
    check("rst_att", attempts, 0);

    // Basic entry cycle
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0; code = GOOD; code_ack = 1'b1; tick();
    check("basic_open1", open_gate, 1);
    code_ack = 1'b0; tick();
    check("basic_open2", open_gate, 1);
    vehicle_left = 1'b1; tick();
    check("basic_close", close_gate, 1);
    check("basic_open_off", open_gate, 0);
    check("basic_occ", occupancy, 1);
    vehicle_left = 1'b0; tick();
    check("basic_close_hold", close_gate, 1);
    gate_ack = 1'b1; tick();
    gate_ack = 1'b0;
    check("basic_idle_close", close_gate, 0);
    check("basic_idle_open", open_gate, 0);

    // Attempt limit
    do_reset();
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0;
    for (int i = 1; i <= MAX_ATTEMPTS; i++) begin
      code = BAD; code_ack = 1'b1; tick();
      check("bad_pin_att_hold", attempts, i - 1);
      check("bad_pin_no_open", open_gate, 0);
      code_ack = 1'b0; tick();
      check("bad_pin_att", attempts, i);
      check("bad_pin_alarm", wrong_pin, (i == MAX_ATTEMPTS) ? 1 : 0);
    end
    code = GOOD; code_ack = 1'b1; tick();
    code_ack = 1'b0;
    check("blocked_hold", wrong_pin, 1);
    check("blocked_no_open", open_gate, 0);
    unblock = 1'b1; tick();
    unblock = 1'b0;
    check("unblock_alarm", wrong_pin, 0);
    check("unblock_att", attempts, 0);
    code = GOOD; code_ack = 1'b1; tick();
    code_ack = 1'b0;
    check("unblock_idle", open_gate, 0);

    // Tailgating, then reset while BLOCKED
    do_reset();
    vehicle_arrival = 1'b1; tick();
    code = GOOD; code_ack = 1'b1; tick();
    code_ack = 1'b0;
    vehicle_left = 1'b1; tick();
    check("tg_blocked", blocked_gate, 1);
    check("tg_wrong", wrong_pin, 0);
    check("tg_open", open_gate, 0);
    check("tg_occ", occupancy, 1);
    vehicle_left = 1'b0; vehicle_arrival = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_blk_alarm", blocked_gate, 0);
    check("rst_blk_occ", occupancy, 0);

    // Full lot
    do_reset();
    admit();
    admit();
    check("full_occ", occupancy, 2);
    check("full_flag", lot_full, 1);
    vehicle_arrival = 1'b1; tick(); tick();
    code = GOOD; code_ack = 1'b1; tick();
    check("full_ignored", open_gate, 0);
    code_ack = 1'b0; vehicle_arrival = 1'b0;
    vehicle_exit = 1'b1; tick();
    vehicle_exit = 1'b0;
    check("exit_occ", occupancy, 1);
    check("exit_full", lot_full, 0);
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0; code_ack = 1'b1; tick();
    code_ack = 1'b0;
    check("reaccept_open", open_gate, 1);
    vehicle_left = 1'b1; vehicle_exit = 1'b1; tick();
    vehicle_left = 1'b0; vehicle_exit = 1'b0;
    check("incdec_occ", occupancy, 1);
    check("incdec_close", close_gate, 1);
    gate_ack = 1'b1; tick();
    gate_ack = 1'b0;

    // Retreat after a wrong PIN; vehicle_left beats code_ack
    do_reset();
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0; code = BAD; code_ack = 1'b1; tick();
    code_ack = 1'b0; tick();
    check("retreat_att1", attempts, 1);
    vehicle_left = 1'b1; code = GOOD; code_ack = 1'b1; tick();
    vehicle_left = 1'b0; code_ack = 1'b0;
    check("retreat_att0", attempts, 0);
    check("retreat_no_open", open_gate, 0);

    // Ack on the last WAIT_PIN cycle is accepted in either build
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) tick();
    code = GOOD; code_ack = 1'b1; tick();
    code_ack = 1'b0;
    check("tmo_edge_open", open_gate, 1);
    vehicle_left = 1'b1; tick();
    vehicle_left = 1'b0; gate_ack = 1'b1; tick();
    gate_ack = 1'b0;

    // One cycle later the timeout (if built) has returned to IDLE
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0;
    repeat (TIMEOUT_CYCLES) tick();
    code = GOOD; code_ack = 1'b1; tick();
    code_ack = 1'b0;
`ifdef PARKING_TIMEOUT_EN
    check("tmo_expired", open_gate, 0);
`else
    check("tmo_none", open_gate, 1);
`endif

    // Reset while OPEN, then exit on an empty lot
    do_reset();
    admit();
    vehicle_arrival = 1'b1; tick();
    vehicle_arrival = 1'b0; code = GOOD; code_ack = 1'b1; tick();
    code_ack = 1'b0;
    check("rst_open_pre", open_gate, 1);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_open_gate", open_gate, 0);
    check("rst_open_close", close_gate, 0);
    check("rst_open_occ", occupancy, 0);
    vehicle_exit = 1'b1; tick();
    vehicle_exit = 1'b0;
    check("empty_exit", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
